// File: rtl/cache_miss_ctrl_if.sv
// Miss-request, data-array and memory-burst signals of the cache miss sequencer.
// master = the sequencer, slave = lookup stage / data array / memory side.
interface cache_miss_ctrl_if #(
  parameter int SET_BITS    = 3,
  parameter int WAY_BITS    = 2,
  parameter int TAG_BITS    = 5,
  parameter int OFFSET_BITS = 4,
  parameter int DATA_W      = 32
);
  logic                         miss_valid;
  logic                         miss_ready;
  logic [SET_BITS-1:0]          miss_set;
  logic [WAY_BITS-1:0]          miss_way;
  logic [TAG_BITS-1:0]          miss_tag;
  logic                         victim_dirty;
  logic [TAG_BITS-1:0]          victim_tag;

  logic                         arr_rd_en;
  logic                         arr_wr_en;
  logic [SET_BITS-1:0]          arr_set;
  logic [WAY_BITS-1:0]          arr_way;
  logic [OFFSET_BITS-1:0]       arr_offset;
  logic [DATA_W-1:0]            arr_wdata;
  logic [DATA_W-1:0]            arr_rdata;

  logic                         mem_cmd_valid;
  logic                         mem_cmd_ready;
  logic                         mem_cmd_we;
  logic [TAG_BITS+SET_BITS-1:0] mem_cmd_blk;
  logic                         mem_wvalid;
  logic                         mem_wready;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_rvalid;
  logic [DATA_W-1:0]            mem_rdata;

  logic                         fill_done;
  logic [SET_BITS-1:0]          fill_set;
  logic [WAY_BITS-1:0]          fill_way;
  logic [TAG_BITS-1:0]          fill_tag;
  logic                         busy;

  modport master (
    input  miss_valid, miss_set, miss_way, miss_tag, victim_dirty, victim_tag,
    input  arr_rdata, mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata,
    output miss_ready, arr_rd_en, arr_wr_en, arr_set, arr_way, arr_offset, arr_wdata,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_blk, mem_wvalid, mem_wdata,
    output fill_done, fill_set, fill_way, fill_tag, busy
  );

  modport slave (
    output miss_valid, miss_set, miss_way, miss_tag, victim_dirty, victim_tag,
    output arr_rdata, mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata,
    input  miss_ready, arr_rd_en, arr_wr_en, arr_set, arr_way, arr_offset, arr_wdata,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_blk, mem_wvalid, mem_wdata,
    input  fill_done, fill_set, fill_way, fill_tag, busy
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: dirty victim write-back then 16-beat refill; clean miss fill_done 18 cycles after accept.
// Stalls on mem_cmd_ready/mem_wready, refill beats never stalled. MISSCTRL_STATS_EN adds wb_count/rf_count.
module cache_miss_ctrl #(
  parameter int SET_BITS    = 3,
  parameter int WAY_BITS    = 2,
  parameter int TAG_BITS    = 5,
  parameter int OFFSET_BITS = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_miss_ctrl_if.master bus
`ifdef MISSCTRL_STATS_EN
  ,
  output logic [15:0]       wb_count,
  output logic [15:0]       rf_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, WB_CMD, WB_RD, WB_LAT, WB_WR, RF_CMD, RF_DATA, DONE
  } stateT;

  stateT                        state;
  logic [OFFSET_BITS-1:0]       cnt;
  logic [DATA_W-1:0]            wdataQ;
  logic [SET_BITS-1:0]          setQ;
  logic [WAY_BITS-1:0]          wayQ;
  logic [TAG_BITS-1:0]          tagQ;
  logic [TAG_BITS-1:0]          vtagQ;

  logic                         missReadyQ;
  logic                         busyQ;
  logic                         cmdValidQ;
  logic                         cmdWeQ;
  logic [TAG_BITS+SET_BITS-1:0] cmdBlkQ;
  logic                         wvalidQ;
  logic                         rdEnQ;
  logic                         fillDoneQ;
  logic                         rfBeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wdataQ     <= '0;
      setQ       <= '0;
      wayQ       <= '0;
      tagQ       <= '0;
      vtagQ      <= '0;
      missReadyQ <= 1'b1;
      busyQ      <= 1'b0;
      cmdValidQ  <= 1'b0;
      cmdWeQ     <= 1'b0;
      cmdBlkQ    <= '0;
      wvalidQ    <= 1'b0;
      rdEnQ      <= 1'b0;
      fillDoneQ  <= 1'b0;
    end else begin
      rdEnQ     <= 1'b0;
      fillDoneQ <= 1'b0;
      case (state)
        IDLE: if (bus.miss_valid) begin
          setQ       <= bus.miss_set;
          wayQ       <= bus.miss_way;
          tagQ       <= bus.miss_tag;
          vtagQ      <= bus.victim_tag;
          cnt        <= '0;
          missReadyQ <= 1'b0;
          busyQ      <= 1'b1;
          cmdValidQ  <= 1'b1;
          cmdWeQ     <= bus.victim_dirty;
          cmdBlkQ    <= bus.victim_dirty ? {bus.victim_tag, bus.miss_set}
                                         : {bus.miss_tag, bus.miss_set};
          state      <= bus.victim_dirty ? WB_CMD : RF_CMD;
        end
        WB_CMD: if (bus.mem_cmd_ready) begin
          cmdValidQ <= 1'b0;
          cmdWeQ    <= 1'b0;
          cmdBlkQ   <= '0;
          rdEnQ     <= 1'b1;
          state     <= WB_RD;
        end
        WB_RD: state <= WB_LAT;
        WB_LAT: begin
          wdataQ  <= bus.arr_rdata;
          wvalidQ <= 1'b1;
          state   <= WB_WR;
        end
        WB_WR: if (bus.mem_wready) begin
          wvalidQ <= 1'b0;
          if (cnt == '1) begin
            cnt       <= '0;
            cmdValidQ <= 1'b1;
            cmdWeQ    <= 1'b0;
            cmdBlkQ   <= {tagQ, setQ};
            state     <= RF_CMD;
          end else begin
            cnt   <= cnt + 1'b1;
            rdEnQ <= 1'b1;
            state <= WB_RD;
          end
        end
        RF_CMD: if (bus.mem_cmd_ready) begin
          cmdValidQ <= 1'b0;
          cmdBlkQ   <= '0;
          state     <= RF_DATA;
        end
        RF_DATA: if (bus.mem_rvalid) begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            fillDoneQ <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          missReadyQ <= 1'b1;
          busyQ      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refill beats go straight into the array in the cycle they arrive.
  assign rfBeat         = (state == RF_DATA) && bus.mem_rvalid;

  assign bus.miss_ready    = missReadyQ;
  assign bus.busy          = busyQ;
  assign bus.mem_cmd_valid = cmdValidQ;
  assign bus.mem_cmd_we    = cmdWeQ;
  assign bus.mem_cmd_blk   = cmdBlkQ;
  assign bus.mem_wvalid    = wvalidQ;
  assign bus.mem_wdata     = wdataQ;
  assign bus.arr_rd_en     = rdEnQ;
  assign bus.arr_wr_en     = rfBeat;
  assign bus.arr_wdata     = rfBeat ? bus.mem_rdata : '0;
  assign bus.arr_set       = setQ;
  assign bus.arr_way       = wayQ;
  assign bus.arr_offset    = cnt;
  assign bus.fill_done     = fillDoneQ;
  assign bus.fill_set      = setQ;
  assign bus.fill_way      = wayQ;
  assign bus.fill_tag      = tagQ;

`ifdef MISSCTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count <= '0;
      rf_count <= '0;
    end else begin
      if (state == IDLE && bus.miss_valid && bus.victim_dirty && wb_count != 16'hFFFF)
        wb_count <= wb_count + 1'b1;
      if (fillDoneQ && rf_count != 16'hFFFF)
        rf_count <= rf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: bench-side array and burst memory models, expected
// commands/beats/writes/fills queued at miss issue and popped as the DUT produces them.
module tb_cache_miss_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_miss_ctrl_if bus ();

`ifdef MISSCTRL_STATS_EN
  logic [15:0] wb_count;
  logic [15:0] rf_count;
  cache_miss_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .wb_count(wb_count), .rf_count(rf_count));
`else
  cache_miss_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic we; logic [7:0] blk; int lat; } cmdT;
  typedef struct { logic [2:0] set; logic [1:0] way; logic [3:0] off; logic [31:0] dat; } wrT;
  typedef struct { logic [2:0] set; logic [1:0] way; logic [4:0] tag; int lat; } fillT;

  cmdT         expCmd[$];
  logic [31:0] expWb[$];
  wrT          expWr[$];
  fillT        expFill[$];

  logic [31:0] arrMem [8][4][16];

  function automatic logic [31:0] refillWord(input logic [7:0] blk, input int i);
    if (blk == 8'h9D) return 32'd100 + 32'(i);
    return {16'hC0DE, blk, 8'(i)};
  endfunction

  // environment knobs and state
  int   cyc = 0;
  int   cmdStall = 0, cmdWait = 0;
  int   wStallBeat = -1, wWait = 0, wbBeat = 0;
  bit   gapMode = 0, gapPhase = 0, strayReq = 0;
  bit   rfActive = 0;
  logic [7:0] rfBlk = '0;
  int   rfIdx = 0;
  int   lastAccept = -100, lastFillCyc = -100;
  int   wrCount = 0, fillCount = 0;
  bit   chkIdleNext = 0, cmdSeen = 0, wHeld = 0;
  logic [7:0]  cmdBlkHold = '0;
  logic        cmdWeHold = 0;
  int          cmdFirstCyc = 0;
  logic [31:0] wHold = '0;
  logic        prevRd = 0;
  logic [2:0]  prevSet = '0;
  logic [1:0]  prevWay = '0;
  logic [3:0]  prevOff = '0;

  initial begin
    cmdT  c;
    wrT   w;
    fillT f;
    logic [31:0] wb;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_wready    = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = 32'h5A5A5A5A;
    bus.arr_rdata     = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.arr_rdata     = prevRd ? arrMem[prevSet][prevWay][prevOff] : 32'hDEADBEEF;
      bus.mem_cmd_ready = (cmdWait == 0);
      bus.mem_wready    = !(wbBeat == wStallBeat && wWait > 0);
      bus.mem_rvalid    = 1'b0;
      bus.mem_rdata     = 32'h5A5A5A5A;
      if (rfActive && (!gapMode || gapPhase)) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = refillWord(rfBlk, rfIdx);
        rfIdx++;
        if (rfIdx == 16) rfActive = 0;
      end else if (strayReq) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0BAD0;
        strayReq = 0;
      end
      gapPhase = ~gapPhase;
      #1;
      if (rst) begin
        rfActive = 0; cmdSeen = 0; wHeld = 0; prevRd = 0; chkIdleNext = 0;
        wbBeat = 0; cmdWait = cmdStall;
      end else begin
        if (chkIdleNext) begin
          checkVal("ready_after_fill", 64'(bus.miss_ready), 64'd1);
          checkVal("busy_after_fill", 64'(bus.busy), 64'd0);
          chkIdleNext = 0;
        end
        if (bus.arr_rd_en || bus.arr_wr_en)
          checkVal("rd_wr_exclusive", 64'(bus.arr_rd_en & bus.arr_wr_en), 64'd0);
        prevRd  = bus.arr_rd_en;
        prevSet = bus.arr_set;
        prevWay = bus.arr_way;
        prevOff = bus.arr_offset;

        if (bus.mem_cmd_valid) begin
          if (!cmdSeen) begin
            cmdSeen = 1; cmdBlkHold = bus.mem_cmd_blk; cmdWeHold = bus.mem_cmd_we;
            cmdFirstCyc = cyc + 1;
          end else begin
            checkVal("cmd_blk_stable", 64'(bus.mem_cmd_blk), 64'(cmdBlkHold));
            checkVal("cmd_we_stable", 64'(bus.mem_cmd_we), 64'(cmdWeHold));
          end
          if (bus.mem_cmd_ready) begin
            if (expCmd.size() == 0) checkVal("cmd_extra", 64'd1, 64'd0);
            else begin
              c = expCmd.pop_front();
              checkVal("cmd_we", 64'(bus.mem_cmd_we), 64'(c.we));
              checkVal("cmd_blk", 64'(bus.mem_cmd_blk), 64'(c.blk));
              if (c.lat >= 0) checkVal("cmd_latency", 64'(cmdFirstCyc - lastAccept), 64'(c.lat));
            end
            cmdSeen = 0;
            cmdWait = cmdStall;
            if (!bus.mem_cmd_we) begin
              rfActive = 1; rfBlk = bus.mem_cmd_blk; rfIdx = 0; gapPhase = 1;
            end
          end else if (cmdWait > 0) cmdWait--;
        end

        if (bus.mem_wvalid) begin
          if (!wHeld) begin wHeld = 1; wHold = bus.mem_wdata; end
          else checkVal("wdata_stable", 64'(bus.mem_wdata), 64'(wHold));
          if (bus.mem_wready) begin
            if (expWb.size() == 0) checkVal("wb_extra", 64'd1, 64'd0);
            else begin
              wb = expWb.pop_front();
              checkVal("wb_data", 64'(bus.mem_wdata), 64'(wb));
            end
            wHeld = 0;
            wbBeat = (wbBeat == 15) ? 0 : wbBeat + 1;
          end else if (wWait > 0) wWait--;
        end

        if (bus.arr_wr_en) begin
          wrCount++;
          arrMem[bus.arr_set][bus.arr_way][bus.arr_offset] = bus.arr_wdata;
          if (expWr.size() == 0) checkVal("wr_extra", 64'd1, 64'd0);
          else begin
            w = expWr.pop_front();
            checkVal("wr_addr", 64'({bus.arr_set, bus.arr_way, bus.arr_offset}), 64'({w.set, w.way, w.off}));
            checkVal("wr_data", 64'(bus.arr_wdata), 64'(w.dat));
          end
        end

        if (bus.fill_done) begin
          fillCount++;
          lastFillCyc = cyc;
          chkIdleNext = 1;
          if (expFill.size() == 0) checkVal("fill_extra", 64'd1, 64'd0);
          else begin
            f = expFill.pop_front();
            checkVal("fill_id", 64'({bus.fill_set, bus.fill_way, bus.fill_tag}), 64'({f.set, f.way, f.tag}));
            if (f.lat >= 0) checkVal("fill_latency", 64'(cyc + 1 - lastAccept), 64'(f.lat));
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic issueMiss(input logic [2:0] set, input logic [1:0] way, input logic [4:0] tag,
                           input bit dirty, input logic [4:0] vtag, input logic [31:0] wbBase,
                           input bit timed);
    cmdT  c;
    wrT   w;
    fillT f;
    int   n;
    logic [7:0] blkN;
    blkN = {tag, set};
    if (dirty) begin
      c.we = 1'b1; c.blk = {vtag, set}; c.lat = timed ? 1 : -1;
      expCmd.push_back(c);
      for (int i = 0; i < 16; i++) expWb.push_back(wbBase + 32'(i));
    end
    c.we = 1'b0; c.blk = blkN; c.lat = (timed && !dirty) ? 1 : -1;
    expCmd.push_back(c);
    for (int i = 0; i < 16; i++) begin
      w.set = set; w.way = way; w.off = 4'(i); w.dat = refillWord(blkN, i);
      expWr.push_back(w);
    end
    f.set = set; f.way = way; f.tag = tag; f.lat = (timed && !dirty) ? 18 : -1;
    expFill.push_back(f);
    bus.miss_valid   = 1'b1;
    bus.miss_set     = set;
    bus.miss_way     = way;
    bus.miss_tag     = tag;
    bus.victim_dirty = dirty;
    bus.victim_tag   = vtag;
    n = 0;
    #1;
    while (!bus.miss_ready && n < 300) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 300) checkVal("accept_timeout", 64'd1, 64'd0);
    lastAccept = cyc + 1;
    @(posedge clk); #1;
    bus.miss_valid   = 1'b0;
    bus.miss_set     = 3'($urandom);
    bus.miss_way     = 2'($urandom);
    bus.miss_tag     = 5'($urandom);
    bus.victim_dirty = ~dirty;
    bus.victim_tag   = 5'($urandom);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (!(expFill.size() == 0 && bus.miss_ready) && n < 2000);
    if (n >= 2000) checkVal({tag, "_timeout"}, 64'd1, 64'd0);
    checkVal({tag, "_leftover"}, 64'(expCmd.size() + expWb.size() + expWr.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fillsBefore, b2bFill;
    bus.miss_valid   = 1'b0;
    bus.miss_set     = '0;
    bus.miss_way     = '0;
    bus.miss_tag     = '0;
    bus.victim_dirty = 1'b0;
    bus.victim_tag   = '0;
    for (int s = 0; s < 8; s++)
      for (int wy = 0; wy < 4; wy++)
        for (int i = 0; i < 16; i++) arrMem[s][wy][i] = '0;
    for (int i = 0; i < 16; i++) begin
      arrMem[3][1][i] = 32'hA0 + 32'(i);
      arrMem[6][3][i] = 32'h600 + 32'(i);
      arrMem[0][1][i] = 32'h500 + 32'(i);
    end

    // outputs while reset is held
    repeat (2) @(posedge clk);
    #2;
    checkVal("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
    checkVal("rst_busy", 64'(bus.busy), 64'd0);
    checkVal("rst_cmd_valid", 64'(bus.mem_cmd_valid), 64'd0);
    checkVal("rst_wvalid", 64'(bus.mem_wvalid), 64'd0);
    checkVal("rst_strobes", 64'({bus.arr_rd_en, bus.arr_wr_en, bus.fill_done}), 64'd0);
    checkVal("rst_arr_wdata", 64'(bus.arr_wdata), 64'd0);
    checkVal("rst_fields", 64'({bus.mem_cmd_blk, bus.fill_set, bus.fill_way, bus.fill_tag, bus.arr_offset}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // clean miss with zero wait states, timing checked
    issueMiss(3'd5, 2'd2, 5'h13, 1'b0, 5'h00, 32'h0, 1'b1);
    waitIdle("clean");

    // dirty miss: write-back of 0xA0..0xAF then refill
    fillsBefore = fillCount;
    issueMiss(3'd3, 2'd1, 5'h07, 1'b1, 5'h04, 32'hA0, 1'b0);
    waitIdle("dirty");
    checkVal("dirty_fill_once", 64'(fillCount - fillsBefore), 64'd1);

    // command and write-beat backpressure
    cmdStall = 5; cmdWait = 5; wStallBeat = 9; wWait = 3;
    issueMiss(3'd6, 2'd3, 5'h02, 1'b1, 5'h11, 32'h600, 1'b0);
    waitIdle("backpressure");
    cmdStall = 0; cmdWait = 0; wStallBeat = -1; wWait = 0;

    // stray rvalid while idle, then gapped refill
    strayReq = 1;
    repeat (3) @(posedge clk);
    #1;
    gapMode = 1;
    issueMiss(3'd2, 2'd0, 5'h1F, 1'b0, 5'h00, 32'h0, 1'b0);
    waitIdle("gapped");
    gapMode = 0;

    // reset during refill beat 7
    wrCount = 0;
    issueMiss(3'd1, 2'd0, 5'h0A, 1'b0, 5'h00, 32'h0, 1'b0);
    n = 0;
    while (wrCount < 7 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checkVal("beat7_reached", 64'(wrCount), 64'd7);
    fillsBefore = fillCount;
    rst = 1'b1;
    expCmd.delete(); expWb.delete(); expWr.delete(); expFill.delete();
    #1;
    checkVal("midrst_busy", 64'(bus.busy), 64'd0);
    checkVal("midrst_ready", 64'(bus.miss_ready), 64'd1);
    checkVal("midrst_wr_en", 64'(bus.arr_wr_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    checkVal("midrst_no_fill", 64'(fillCount - fillsBefore), 64'd0);
    checkVal("midrst_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // back-to-back: dirty miss, then a clean request held while busy
    issueMiss(3'd0, 2'd1, 5'h0C, 1'b1, 5'h15, 32'h500, 1'b0);
    b2bFill = fillCount;
    issueMiss(3'd7, 2'd3, 5'h01, 1'b0, 5'h00, 32'h0, 1'b0);
    checkVal("b2b_first_filled", 64'(fillCount - b2bFill), 64'd1);
    checkVal("b2b_accept_gap", 64'(lastAccept - lastFillCyc), 64'd2);
    waitIdle("b2b");
`ifdef MISSCTRL_STATS_EN
    checkVal("wb_count", 64'(wb_count), 64'd1);
    checkVal("rf_count", 64'(rf_count), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
